// File: rtl/nic_axi_rd_splitter.sv
// AXI4 read-burst splitter: INCR size-2 bursts are reissued as sub-bursts that never cross a
// BOUNDARY_BYTES window. Define NIC_RD_SPLIT_RESP_STICKY_EN to hold the first error response.
module nic_axi_rd_splitter #(
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned BOUNDARY_BYTES = 64
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic [3:0]            s_arcache,
    input  logic                  s_arvalid,
    output logic                  s_arready,

    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready,

    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic [3:0]            m_arcache,
    output logic                  m_arvalid,
    input  logic                  m_arready,

    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam int unsigned BndBits  = $clog2(BOUNDARY_BYTES);
    localparam int unsigned BndWords = BOUNDARY_BYTES / 4;
    localparam logic [ADDR_WIDTH-1:0] BndMask = ADDR_WIDTH'(BOUNDARY_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BndSize = ADDR_WIDTH'(BOUNDARY_BYTES);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                state;
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            cache;
    logic [8:0]            ar_left;
    logic [8:0]            rd_left;

    logic                  split;
    logic [12:0]           room;
    logic [8:0]            sub_len;
    logic [8:0]            sub_len_m1;
    logic [ADDR_WIDTH-1:0] next_bnd;
    logic                  r_active;
    logic                  r_fire;
    logic                  ar_fire;
    logic                  unused_inputs;

    assign split = (burst == 2'b01) && (size == 3'd2);

    // Beats left before the next boundary, measured in 32-bit words.
    always_comb begin
        room    = 13'(BndWords) - 13'(addr[BndBits-1:0] >> 2);
        sub_len = ar_left;
        if (split && (room < 13'(ar_left))) begin
            sub_len = room[8:0];
        end
    end

    assign sub_len_m1 = sub_len - 9'd1;
    assign next_bnd   = (addr & ~BndMask) + BndSize;

    assign r_active = (state != StIdle);
    assign r_fire   = r_active && m_rvalid && s_rready;
    assign ar_fire  = m_arvalid && m_arready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= StIdle;
            m_arvalid <= 1'b0;
            id        <= '0;
            addr      <= '0;
            size      <= '0;
            burst     <= '0;
            cache     <= '0;
            ar_left   <= '0;
            rd_left   <= '0;
        end else begin
            if (r_fire) begin
                rd_left <= rd_left - 9'd1;
            end
            unique case (state)
                StIdle: begin
                    if (s_arvalid) begin
                        id        <= s_arid;
                        addr      <= s_araddr;
                        size      <= s_arsize;
                        burst     <= s_arburst;
                        cache     <= s_arcache;
                        ar_left   <= {1'b0, s_arlen} + 9'd1;
                        rd_left   <= {1'b0, s_arlen} + 9'd1;
                        m_arvalid <= 1'b1;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (ar_fire) begin
                        ar_left <= ar_left - sub_len;
                        if (split) begin
                            addr <= next_bnd;
                        end
                        if (ar_left == sub_len) begin
                            m_arvalid <= 1'b0;
                            // Last data beat may complete alongside the last address beat.
                            state <= (r_fire && rd_left == 9'd1) ? StIdle : StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (r_fire && rd_left == 9'd1) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign s_arready = (state == StIdle) && !areset;

    assign m_arid    = id;
    assign m_araddr  = addr;
    assign m_arlen   = sub_len_m1[7:0];
    assign m_arsize  = size;
    assign m_arburst = burst;
    assign m_arcache = cache;

    assign s_rvalid = r_active && m_rvalid;
    assign m_rready = r_active && s_rready;
    assign s_rdata  = m_rdata;
    assign s_rid    = id;
    assign s_rlast  = (rd_left == 9'd1);

`ifdef NIC_RD_SPLIT_RESP_STICKY_EN
    logic       resp_held;
    logic [1:0] resp_hold;

    always_ff @(posedge aclk) begin
        if (areset || state == StIdle) begin
            resp_held <= 1'b0;
            resp_hold <= 2'b00;
        end else if (r_fire && !resp_held && m_rresp != 2'b00) begin
            resp_held <= 1'b1;
            resp_hold <= m_rresp;
        end
    end

    assign s_rresp = resp_held ? resp_hold : m_rresp;
`else
    assign s_rresp = m_rresp;
`endif

    // Downstream ID and last flag are not needed: one burst in flight, beats counted locally.
    assign unused_inputs = ^{m_rid, m_rlast};

endmodule

// File: doc/nic_axi_rd_splitter.md
# nic_axi_rd_splitter

Read-burst splitter between the e1000 DMA AXI4 master read channels and the PCI master bridge read channels. It takes one INCR read burst of up to 256 beats from the NIC and reissues it downstream as a sequence of sub-bursts, none of which crosses a `BOUNDARY_BYTES` address boundary. This keeps every PCI read inside one cacheline-aligned window. Read data returns through the block in order, with `rid` and `rlast` reconstructed for the original burst.

## Interface
Parameters:
- `ID_WIDTH`, 4, AXI ID width.
- `ADDR_WIDTH`, 64, AXI address width.
- `BOUNDARY_BYTES`, 64, split boundary in bytes. Must be a power of two, 4..4096.

Ports:
- `aclk`  in  1  clock, all logic on the rising edge.
- `areset`  in  1  reset, synchronous, active-high.
- `s_arid`/`s_araddr`/`s_arlen`/`s_arsize`/`s_arburst`/`s_arcache`  in  ID_WIDTH/ADDR_WIDTH/8/3/2/4  upstream read address.
- `s_arvalid` in 1; `s_arready` out 1  upstream AR handshake.
- `s_rid`/`s_rdata`/`s_rresp`/`s_rlast`  out  ID_WIDTH/32/2/1  upstream read data.
- `s_rvalid` out 1; `s_rready` in 1  upstream R handshake.
- `m_arid`/`m_araddr`/`m_arlen`/`m_arsize`/`m_arburst`/`m_arcache`  out  same widths as `s_ar*`  downstream read address.
- `m_arvalid` out 1; `m_arready` in 1  downstream AR handshake.
- `m_rid`/`m_rdata`/`m_rresp`/`m_rlast`  in  ID_WIDTH/32/2/1  downstream read data.
- `m_rvalid` in 1; `m_rready` out 1  downstream R handshake.

## Operation
- States: IDLE, ISSUE, DRAIN. One upstream burst is in flight at a time.
- IDLE
  - `s_arready`=1.
  - On `s_arvalid`: latch id, addr, size, burst, cache.
  - Set `ar_left` = `rd_left` = `arlen`+1 (9-bit counters).
  - Go to ISSUE.
- Split mode applies when `arburst`=INCR and `arsize`=2.
  - Each sub-burst length is min(`ar_left`, `BOUNDARY_BYTES`/4 − `addr[log2(BOUNDARY_BYTES)-1:2]`) beats.
  - `m_arlen` = that length − 1.
  - The next sub-burst address is the next boundary (low bits cleared).
- Pass mode applies to FIXED, WRAP, or any size ≠ 2: one downstream burst, identical to the upstream one.
- ISSUE
  - `m_arvalid`=1. `m_arid`, `m_arsize`, `m_arburst`, `m_arcache` are the latched values.
  - On `m_arready`: subtract the sub-burst length from `ar_left` and advance the address.
  - When `ar_left` reaches 0, go to DRAIN. Otherwise the next sub-burst is presented on the following cycle.
- R path, combinational, active in ISSUE and DRAIN:
  - `s_rvalid`=`m_rvalid`, `m_rready`=`s_rready`, `s_rdata`=`m_rdata`.
  - `s_rid` = latched id.
  - `s_rlast` = (`rd_left`==1).
  - `m_rlast` is ignored.
  - Each R handshake decrements `rd_left`.
- DRAIN: when `rd_left` reaches 0, go to IDLE.
- In IDLE, `m_rready`=0 and `s_rvalid`=0. Stray downstream beats are held, not dropped.
- AR issue and R beats proceed concurrently. The R handshake of the final beat can share a cycle with the final `m_ar` handshake; `rd_left` governs the exit from DRAIN.

## Timing
- Reset values: `s_arready`=0 during reset and 1 from the first cycle after; `m_arvalid`=0; `s_rvalid`=0; `m_rready`=0; state IDLE; counters 0.
- AR latency: `m_arvalid` rises the cycle after the `s_ar` handshake. There is one sub-burst per cycle under continuous `m_arready`.
- R latency: zero cycles, no buffering. Backpressure propagates in the same cycle.
- `m_ar*` remain stable while `m_arvalid`=1 and `m_arready`=0.
- Reset mid-operation: everything returns to reset values the next cycle. In-flight downstream beats are abandoned; the downstream side is reset together with this block.

## Configuration
- `NIC_RD_SPLIT_RESP_STICKY_EN` defined:
  - The first non-OKAY `m_rresp` in an upstream burst is latched.
  - `s_rresp` returns the latched value for that beat and every later beat of the burst.
  - The latch clears on entry to IDLE.
- Not defined: `s_rresp`=`m_rresp` per beat.

## Test plan
- `araddr`=0x1000, `arlen`=15, INCR, size 2 → one `m_ar`: 0x1000 len 15. 16 beats; `s_rlast` on beat 16 only.
- `araddr`=0x1038, `arlen`=7 → `m_ar` 0x1038 len 1, then 0x1040 len 5. `s_rlast` only on beat 8; downstream `m_rlast` at beat 2 is not forwarded.
- `araddr`=0x2004, `arlen`=255 → 17 sub-bursts: 0x2004 len 14; 0x2040..0x23C0 len 15 each; 0x2400 len 0. 256 beats, `rid` constant.
- WRAP burst, `araddr`=0x3008, `arlen`=3 → single identical `m_ar`. `m_arready` held low 3 cycles → `m_ar*` stable.
- `s_rready` low 5 cycles mid-burst → `m_rready` low, `s_rdata` stable. SLVERR on beat 3 of 8 → beats 3..8 SLVERR with macro; only beat 3 without.
- `areset` pulsed in DRAIN → next cycle `s_rvalid`=0, `m_arvalid`=0. `s_arready`=1 the first cycle after release.
